hazard_intr_controller: RTL and testbench

- Central pipeline sequencer for the five-stage processor. It sits beside the decode stage and drives the PC, IF/ID and ID/EX control.
- Detects load-use hazards and taken-branch flushes.
- Sequences the multi-cycle interrupt entry: drain the pipeline, push the PC to the stack in halves, then redirect to the vector.
- Owns every stall, flush and PC-select decision so that no other stage computes them independently.

---
 rtl/hazard_intr_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_intr_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_intr_controller.sv
// Central stall/flush/PC-select sequencer for the five-stage pipeline:
// load-use bubbles, branch flushes and multi-cycle interrupt entry.
module hazard_intr_controller #(
   parameter int DRAIN_CYCLES = 2,
   parameter int PUSH_BEATS   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] id_src,
   input  logic [2:0] id_dst,
   input  logic       id_uses_src,
   input  logic       id_uses_dst,
   input  logic       ex_mem_read,
   input  logic [2:0] ex_wa,
   input  logic       branch_taken,
   input  logic       intr,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic [1:0] pc_sel,
   output logic       intr_push,
   output logic [1:0] push_beat,
   output logic       intr_ack
);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      PUSH,
      VECTOR
   } state_t;

   localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
   localparam logic [2:0] PUSH_LAST  = 3'(PUSH_BEATS - 1);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       intr_q;
   logic       pend_q, pend_d;
   logic       intr_edge;
   logic       load_use;

   assign intr_edge = intr & ~intr_q;

   assign load_use = ex_mem_read &
                     ((id_uses_src & (id_src == ex_wa)) |
                      (id_uses_dst & (id_dst == ex_wa)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         intr_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         intr_q  <= intr;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q | intr_edge;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      pc_sel     = 2'd0;
      intr_push  = 1'b0;
      push_beat  = 2'd0;
      intr_ack   = 1'b0;

      unique case (state_q)
         RUN: begin
            // Branch wins: a load-use on the wrong path is moot.
            if (branch_taken) begin
               pc_sel     = 2'd1;
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (pend_q) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = DRAIN;
               cnt_d      = 3'd0;
            end else if (load_use) begin
               idex_flush = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end
         DRAIN: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
               state_d = PUSH;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         PUSH: begin
            intr_push  = 1'b1;
            push_beat  = cnt_q[1:0];
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (cnt_q == PUSH_LAST) begin
               state_d = VECTOR;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         VECTOR: begin
            pc_sel     = 2'd2;
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            intr_ack   = 1'b1;
            state_d    = RUN;
            pend_d     = intr_edge;
         end
         default: begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      endcase

      if (!rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         pc_sel     = 2'd0;
         intr_push  = 1'b0;
         push_beat  = 2'd0;
         intr_ack   = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_intr_controller.sv
// Directed-vector bench for hazard_intr_controller with default
// parameters; expected values are hand-computed per cycle.
module tb_hazard_intr_controller;

   logic       clk;
   logic       rst;
   logic [2:0] id_src;
   logic [2:0] id_dst;
   logic       id_uses_src;
   logic       id_uses_dst;
   logic       ex_mem_read;
   logic [2:0] ex_wa;
   logic       branch_taken;
   logic       intr;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_flush;
   logic [1:0] pc_sel;
   logic       intr_push;
   logic [1:0] push_beat;
   logic       intr_ack;

   int nvec;
   int nerr;
   int acks;

   hazard_intr_controller dut (
      .clk          (clk),
      .rst          (rst),
      .id_src       (id_src),
      .id_dst       (id_dst),
      .id_uses_src  (id_uses_src),
      .id_uses_dst  (id_uses_dst),
      .ex_mem_read  (ex_mem_read),
      .ex_wa        (ex_wa),
      .branch_taken (branch_taken),
      .intr         (intr),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .pc_sel       (pc_sel),
      .intr_push    (intr_push),
      .push_beat    (push_beat),
      .intr_ack     (intr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      id_src       = 3'd0;
      id_dst       = 3'd0;
      id_uses_src  = 1'b0;
      id_uses_dst  = 1'b0;
      ex_mem_read  = 1'b0;
      ex_wa        = 3'd0;
      branch_taken = 1'b0;
   endtask

   task automatic chk_run(input string tag);
      chk({tag, ".pc_write"}, int'(pc_write), 1);
      chk({tag, ".ifid_write"}, int'(ifid_write), 1);
      chk({tag, ".pc_sel"}, int'(pc_sel), 0);
      chk({tag, ".idex_flush"}, int'(idex_flush), 0);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".pc_write"}, int'(pc_write), 0);
      chk({tag, ".ifid_write"}, int'(ifid_write), 0);
      chk({tag, ".ifid_flush"}, int'(ifid_flush), 1);
      chk({tag, ".idex_flush"}, int'(idex_flush), 1);
      chk({tag, ".intr_push"}, int'(intr_push), 0);
      chk({tag, ".intr_ack"}, int'(intr_ack), 0);
   endtask

   // Cycle k after the pending RUN cycle (k=0): P, D, D, B0, B1, V
   int exp_pcw[6]  = '{0, 0, 0, 0, 0, 1};
   int exp_push[6] = '{0, 0, 0, 1, 1, 0};
   int exp_beat[6] = '{0, 0, 0, 0, 1, 0};
   int exp_sel[6]  = '{0, 0, 0, 0, 0, 2};
   int exp_ack[6]  = '{0, 0, 0, 0, 0, 1};

   initial begin
      nvec = 0;
      nerr = 0;

      rst          = 1'b0;
      id_src       = 3'($urandom_range(0, 7));
      id_dst       = 3'($urandom_range(0, 7));
      id_uses_src  = 1'($urandom_range(0, 1));
      id_uses_dst  = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_wa        = 3'($urandom_range(0, 7));
      branch_taken = 1'($urandom_range(0, 1));
      intr         = 1'($urandom_range(0, 1));
      #1;
      chk_rst("rst0");
      tick();
      branch_taken = 1'b1;
      intr         = 1'b1;
      #1;
      chk_rst("rst1");
      tick();

      quiet();
      intr = 1'b0;
      #1;
      chk_rst("rst_hold");
      rst = 1'b1;
      #1;
      chk_run("post_rst");
      tick();

      ex_mem_read = 1'b1;
      ex_wa       = 3'd3;
      id_src      = 3'd3;
      id_uses_src = 1'b1;
      #1;
      chk("lu_src.pc_write", int'(pc_write), 0);
      chk("lu_src.ifid_write", int'(ifid_write), 0);
      chk("lu_src.idex_flush", int'(idex_flush), 1);
      chk("lu_src.ifid_flush", int'(ifid_flush), 0);
      tick();
      ex_mem_read = 1'b0;
      #1;
      chk_run("lu_after");
      tick();

      ex_mem_read = 1'b1;
      id_uses_src = 1'b0;
      #1;
      chk_run("lu_nouse");
      tick();

      id_uses_dst = 1'b1;
      id_dst      = 3'd3;
      id_src      = 3'd5;
      #1;
      chk("lu_dst.pc_write", int'(pc_write), 0);
      chk("lu_dst.idex_flush", int'(idex_flush), 1);
      tick();

      ex_wa = 3'd4;
      #1;
      chk_run("lu_wa_diff");
      tick();

      ex_wa        = 3'd3;
      id_src       = 3'd3;
      id_uses_src  = 1'b1;
      branch_taken = 1'b1;
      #1;
      chk("br_lu.pc_sel", int'(pc_sel), 1);
      chk("br_lu.pc_write", int'(pc_write), 1);
      chk("br_lu.ifid_flush", int'(ifid_flush), 1);
      chk("br_lu.idex_flush", int'(idex_flush), 1);
      tick();

      quiet();
      intr = 1'b1;
      #1;
      chk_run("intr_edge");
      tick();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("isr%0d.pc_write", k), int'(pc_write), exp_pcw[k]);
         chk($sformatf("isr%0d.intr_push", k), int'(intr_push), exp_push[k]);
         chk($sformatf("isr%0d.push_beat", k), int'(push_beat), exp_beat[k]);
         chk($sformatf("isr%0d.pc_sel", k), int'(pc_sel), exp_sel[k]);
         chk($sformatf("isr%0d.intr_ack", k), int'(intr_ack), exp_ack[k]);
         chk($sformatf("isr%0d.idex_flush", k), int'(idex_flush), 1);
         tick();
      end
      chk_run("isr_done");
      chk("isr_done.intr_ack", int'(intr_ack), 0);
      intr = 1'b0;
      tick();
      chk_run("isr_idle");
      tick();

      intr         = 1'b1;
      branch_taken = 1'b1;
      #1;
      chk("ib0.pc_sel", int'(pc_sel), 1);
      chk("ib0.pc_write", int'(pc_write), 1);
      tick();
      #1;
      chk("ib1.pc_sel", int'(pc_sel), 1);
      chk("ib1.pc_write", int'(pc_write), 1);
      chk("ib1.intr_push", int'(intr_push), 0);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("ib2.pc_write", int'(pc_write), 0);
      chk("ib2.ifid_flush", int'(ifid_flush), 1);
      acks = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 5)
            chk("ib_vec.pc_sel", int'(pc_sel), 2);
         if (intr_ack)
            acks++;
         tick();
      end
      chk("ib.ack_count", acks, 1);
      intr = 1'b0;
      tick();

      intr = 1'b1;
      tick();
      for (int k = 0; k < 4; k++)
         tick();
      chk("mid.intr_push", int'(intr_push), 1);
      chk("mid.push_beat", int'(push_beat), 1);
      rst = 1'b0;
      #1;
      chk_rst("mid_rst");
      tick();
      intr = 1'b0;
      #1;
      chk_rst("mid_rst_hold");
      rst = 1'b1;
      #1;
      acks = 0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("mid_run%0d.pc_write", k), int'(pc_write), 1);
         if (intr_ack)
            acks++;
         tick();
      end
      chk("mid.ack_count", acks, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
